// File: rtl/mem_unit.sv
// Word-addressed single-port memory with valid/ready requests, byte-enabled writes,
// an RD_LATENCY-deep response pipeline and a self-sequencing INIT pass (boot image via MEM_BOOT_IMAGE_EN).
module mem_unit #(
    parameter int MEM_DEPTH  = 64,
    parameter int DATA_WIDTH = 32,
    parameter int RD_LATENCY = 1,
    localparam int ADDR_WIDTH = $clog2(MEM_DEPTH),
    localparam int NB         = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NB-1:0]         req_be,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_we,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done
);

    typedef enum logic {ST_INIT, ST_READY} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(MEM_DEPTH - 1);

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   init_idx;
    logic [DATA_WIDTH-1:0]   init_data;
    logic                    accept;
    logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

    logic [RD_LATENCY-1:0]   vld_p;
    logic [RD_LATENCY-1:0]   we_p;
    logic [DATA_WIDTH-1:0]   rdata_p [RD_LATENCY];

    function automatic logic [DATA_WIDTH-1:0] merge_bytes(
        input logic [DATA_WIDTH-1:0] old_word,
        input logic [DATA_WIDTH-1:0] new_word,
        input logic [NB-1:0]         be
    );
        logic [DATA_WIDTH-1:0] w;
        w = old_word;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) w[8*k +: 8] = new_word[8*k +: 8];
        end
        return w;
    endfunction

`ifdef MEM_BOOT_IMAGE_EN
    localparam logic [31:0] BOOT_IMAGE [8] = '{
        32'h00a00313, 32'h01400393, 32'h00730e33, 32'h40638eb3,
        32'h01de7f33, 32'h01de4fb3, 32'h00000000, 32'h00000000
    };

    always_comb begin
        init_data = '0;
        if (init_idx < ADDR_WIDTH'(8)) init_data = DATA_WIDTH'(BOOT_IMAGE[init_idx[2:0]]);
    end
`else
    always_comb begin
        init_data = '0;
    end
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= ST_INIT;
            init_idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_INIT) init_idx <= init_idx + 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        init_done = 1'b0;
        case (state)
            ST_INIT: begin
                if (init_idx == LAST_IDX) state_nxt = ST_READY;
            end
            ST_READY: begin
                req_ready = 1'b1;
                init_done = 1'b1;
            end
            default: state_nxt = ST_INIT;
        endcase
    end

    assign accept = req_valid && req_ready;

    // INIT owns the write port until the last word is written
    always_ff @(posedge clk) begin
        if (reset_n && state == ST_INIT) begin
            mem[init_idx] <= init_data;
        end else if (accept && req_we) begin
            mem[req_addr] <= merge_bytes(mem[req_addr], req_wdata, req_be);
        end
    end

    // stage p0 captures at the acceptance edge, later stages shift
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            vld_p <= '0;
            we_p  <= '0;
        end else begin
            vld_p[0] <= accept;
            we_p[0]  <= req_we;
            for (int i = 1; i < RD_LATENCY; i++) begin
                vld_p[i] <= vld_p[i-1];
                we_p[i]  <= we_p[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        rdata_p[0] <= req_we ? '0 : mem[req_addr];
        for (int i = 1; i < RD_LATENCY; i++) begin
            rdata_p[i] <= rdata_p[i-1];
        end
    end

    assign rsp_valid = vld_p[RD_LATENCY-1];
    assign rsp_we    = vld_p[RD_LATENCY-1] & we_p[RD_LATENCY-1];
    assign rsp_rdata = vld_p[RD_LATENCY-1] ? rdata_p[RD_LATENCY-1] : '0;

endmodule

// File: tb/tb_mem_unit.sv
// Randomised bench for mem_unit against a cycle-level reference model of the
// request/response contract (memory array plus a queue of due responses).
module tb_mem_unit;

    localparam int DEPTH = 64;
    localparam int DW    = 32;
    localparam int LAT   = 3;
    localparam int AW    = $clog2(DEPTH);

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [3:0]    req_be;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic          init_done;

    mem_unit #(.MEM_DEPTH(DEPTH), .DATA_WIDTH(DW), .RD_LATENCY(LAT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_be    (req_be),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .init_done (init_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        bit          we;
        logic [31:0] data;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] model_mem [DEPTH];
    bit          model_ready;
    int          init_cnt;
    int          cyc;
    int          n_tests;
    int          n_fail;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] boot_word(input int a);
        logic [31:0] w;
        w = 32'h0;
`ifdef MEM_BOOT_IMAGE_EN
        case (a)
            0: w = 32'h00a00313;
            1: w = 32'h01400393;
            2: w = 32'h00730e33;
            3: w = 32'h40638eb3;
            4: w = 32'h01de7f33;
            5: w = 32'h01de4fb3;
            default: w = 32'h0;
        endcase
`endif
        return w;
    endfunction

    task automatic model_reinit();
        for (int a = 0; a < DEPTH; a++) model_mem[a] = boot_word(a);
    endtask

    // One clock: advance the model across the edge, then compare outputs.
    task automatic tick();
        rsp_t        r;
        logic [31:0] w;
        bit          exp_v;
        bit          ready_before;
        ready_before = model_ready;
        @(posedge clk);
        cyc++;
        if (!reset_n) begin
            model_ready = 1'b0;
            init_cnt    = 0;
            exp_q.delete();
            model_reinit();
        end else begin
            if (req_valid && ready_before) begin
                r.due  = cyc + LAT - 1;
                r.we   = req_we;
                r.data = req_we ? 32'h0 : model_mem[req_addr];
                exp_q.push_back(r);
                if (req_we) begin
                    w = model_mem[req_addr];
                    for (int k = 0; k < 4; k++)
                        if (req_be[k]) w[8*k +: 8] = req_wdata[8*k +: 8];
                    model_mem[req_addr] = w;
                end
            end
            if (!model_ready) begin
                init_cnt++;
                if (init_cnt == DEPTH) model_ready = 1'b1;
            end
        end
        #1;
        check("req_ready", {31'h0, req_ready}, {31'h0, model_ready});
        check("init_done", {31'h0, init_done}, {31'h0, model_ready});
        exp_v = (exp_q.size() > 0) && (exp_q[0].due == cyc);
        check("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_v});
        if (exp_v) begin
            r = exp_q.pop_front();
            check("rsp_we", {31'h0, rsp_we}, {31'h0, r.we});
            check("rsp_rdata", rsp_rdata, r.data);
        end else begin
            check("idle_rsp_we", {31'h0, rsp_we}, 32'h0);
            check("idle_rsp_rdata", rsp_rdata, 32'h0);
        end
    endtask

    task automatic req(input bit v, input bit we, input int addr,
                       input logic [3:0] be, input logic [31:0] wd);
        req_valid = v;
        req_we    = we;
        req_addr  = AW'(addr);
        req_be    = be;
        req_wdata = wd;
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) req(1'b0, 1'b0, 0, 4'h0, 32'h0);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        cyc         = 0;
        model_ready = 1'b0;
        init_cnt    = 0;
        model_reinit();
        reset_n     = 1'b0;
        req_valid   = 1'b0;
        req_we      = 1'b0;
        req_addr    = '0;
        req_be      = '0;
        req_wdata   = '0;

        idle(3);
        reset_n = 1'b1;
        // requests offered during INIT must be ignored
        for (int i = 0; i < DEPTH; i++) req(1'b1, i[0], i, 4'hF, 32'hA5A5_0000 | i);
        idle(2);

        req(1'b1, 1'b0, 0, 4'h0, 32'h0);
        req(1'b1, 1'b0, 5, 4'h0, 32'h0);
        req(1'b1, 1'b0, 63, 4'h0, 32'h0);
        idle(LAT);

        req(1'b1, 1'b1, 7, 4'hF, 32'hFFFF_FFFF);
        req(1'b1, 1'b1, 7, 4'b0101, 32'h1234_5678);
        req(1'b1, 1'b0, 7, 4'h0, 32'h0);
        idle(LAT);
        check("byte_merge_word7", model_mem[7], 32'hFF34_FF78);

        req(1'b1, 1'b1, 10, 4'hF, 32'hDEAD_BEEF);
        req(1'b1, 1'b0, 10, 4'h0, 32'h0);
        idle(LAT);

        req(1'b1, 1'b1, 3, 4'h0, 32'hCAFE_F00D);
        req(1'b1, 1'b0, 3, 4'h0, 32'h0);
        req(1'b1, 1'b0, 1, 4'h0, 32'h0);
        req(1'b1, 1'b0, 2, 4'h0, 32'h0);
        idle(LAT);

        for (int i = 0; i < 400; i++) begin
            req($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                (i < 200) ? $urandom_range(0, 15) : $urandom_range(0, DEPTH - 1),
                4'($urandom), $urandom);
        end
        idle(LAT);

        // reset with two reads in flight: both must be dropped
        req(1'b1, 1'b0, 7, 4'h0, 32'h0);
        req(1'b1, 1'b0, 10, 4'h0, 32'h0);
        reset_n = 1'b0;
        idle(1);
        reset_n = 1'b1;
        idle(DEPTH + 2);
        req(1'b1, 1'b0, 7, 4'h0, 32'h0);
        req(1'b1, 1'b0, 10, 4'h0, 32'h0);
        idle(LAT + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
